bcd2bin_seq: RTL and testbench



---
 rtl/bcd2bin_seq_if.sv | 37 +++
 rtl/bcd2bin_seq.sv | 141 ++++++++++++++
 tb/tb_bcd2bin_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: start/busy/done handshake bundle for the BCD-to-binary converter.
//   start  requester -> converter  conversion request (sampled only while idle)
//   in     requester -> converter  packed BCD word, digit 0 in in[3:0]
//   out    converter -> requester  binary result, held until the next completion
//   busy   converter -> requester  conversion in progress
//   done   converter -> requester  one-cycle pulse, out/err valid
//   err    converter -> requester  invalid-digit flag, valid with done
// master: the requester side. slave: the converter side.
interface bcd2bin_seq_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   in;
  logic [BIN_W-1:0]      out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start,
    output in,
    input  out,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  in,
    output out,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter using reverse double dabble.
// Each SHIFT cycle shifts {bcd, bin} right by one bit, then subtracts 3 from every
// BCD digit that is 8 or more. After BIN_W steps bin holds the binary value.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   bcd2bin_seq_if.slave (start, in, out, busy, done, err)
//
// Parameters:
//   DIGITS  number of BCD digits in bus.in
//   BIN_W   result width, 10**DIGITS <= 2**BIN_W
//
// Optional feature: define BCD2BIN_CHECK_EN to flag input digits above 9. A flagged
// conversion completes with err=1 and out=0. Without it err is tied low.
//
// Timing: start accepted at edge k -> busy after k .. k+BIN_W -> done/out after
// edge k+BIN_W+1 for one cycle.
module bcd2bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input logic         clk,
  input logic         rst,
  bcd2bin_seq_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   out_q;
  logic               busy_q;
  logic               done_q;

  // One reverse double-dabble step computed from the current working register.
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;

  always_comb begin
    bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
    bin_d     = {bcd_q[0], bin_q[BIN_W-1:1]};
    bcd_d     = bcd_shift;
    for (int i = 0; i < int'(DIGITS); i++) begin
      // Digit >= 8 is exactly "MSB of the nibble set".
      if (bcd_shift[4*i+3]) begin
        bcd_d[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic invalid_in;
  logic flag_q;
  logic err_q;

  always_comb begin
    invalid_in = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.in[4*i +: 4] > 4'd9) begin
        invalid_in = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            bcd_q   <= bus.in;
            bin_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
`ifdef BCD2BIN_CHECK_EN
            flag_q  <= invalid_in;
`endif
          end
        end
        StShift: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
`ifdef BCD2BIN_CHECK_EN
          out_q <= flag_q ? '0 : bin_q;
          err_q <= flag_q;
`else
          out_q <= bin_q;
`endif
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef BCD2BIN_CHECK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed and randomized checks of bcd2bin_seq against a decimal
// reference model (digit-weighted sum), including latency, handshake and reset cases.
module tb_bcd2bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk = 1'b0;
  logic rst;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal value of a packed BCD word.
  function automatic int ref_val(input logic [4*DIGITS-1:0] v);
    int acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic bit ref_bad(input logic [4*DIGITS-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // One full conversion from IDLE; optionally scrambles in while it runs.
  task automatic run_conv(input logic [15:0] v, input string tag, input bit scramble);
    int busy_cnt = 0;
    int overlap  = 0;
    int lat      = -1;
    bit bad      = ref_bad(v);
    logic [31:0] exp_out = 32'(ref_val(v));
    bus.start = 1'b1;
    bus.in    = v;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (scramble) bus.in = 16'($urandom);
      if (bus.busy && bus.done) overlap++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
      tick();
    end
    check({tag, " latency"}, lat, 15);
    check({tag, " busy cycles"}, busy_cnt, 14);
    check({tag, " busy/done overlap"}, overlap, 0);
`ifdef BCD2BIN_CHECK_EN
    if (bad) exp_out = 0;
    check({tag, " out"}, 32'(bus.out), exp_out);
    check({tag, " err"}, 32'(bus.err), 32'(bad));
`else
    if (!bad) check({tag, " out"}, 32'(bus.out), exp_out);
    check({tag, " err"}, 32'(bus.err), 0);
`endif
    tick();
    check({tag, " done single"}, 32'(bus.done), 0);
`ifdef BCD2BIN_CHECK_EN
    check({tag, " out held"}, 32'(bus.out), exp_out);
`else
    if (!bad) check({tag, " out held"}, 32'(bus.out), exp_out);
`endif
  endtask

  initial begin
    int pulses;
    int last;
    int dones;
    int busys;
    logic [15:0] v;

    // Reset state
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset out", 32'(bus.out), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset err", 32'(bus.err), 0);

    // Directed values
    run_conv(16'h1234, "bcd1234", 1'b1);
    run_conv(16'h9999, "bcd9999", 1'b0);
    run_conv(16'h0000, "bcd0000", 1'b0);
    run_conv(16'h0050, "bcd0050", 1'b1);

    // start held high: one conversion every BIN_W+2 cycles
    bus.start = 1'b1;
    bus.in = 16'h0001;
    pulses = 0;
    last = -1;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) begin
        pulses++;
        check("held out", 32'(bus.out), 1);
        if (last >= 0) check("held interval", c - last, BIN_W + 2);
        last = c;
      end
      tick();
    end
    check("held pulses", pulses, 3);
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("held drained busy", 32'(bus.busy), 0);

    // start pulse mid-SHIFT is ignored and not queued
    bus.start = 1'b1;
    bus.in = 16'h0001;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    bus.start = 1'b1;
    bus.in = 16'h0002;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) begin
        dones++;
        check("midstart out", 32'(bus.out), 1);
      end
      tick();
    end
    check("midstart done count", dones, 1);

    // Reset during SHIFT: no done, out cleared, start on reset edge ignored
    bus.start = 1'b1;
    bus.in = 16'h4321;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.in = 16'h0007;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    check("midreset busy", 32'(bus.busy), 0);
    check("midreset out", 32'(bus.out), 0);
    check("midreset done", 32'(bus.done), 0);
    dones = 0;
    busys = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dones++;
      if (bus.busy) busys++;
      tick();
    end
    check("midreset later done", dones, 0);
    check("midreset later busy", busys, 0);
    run_conv(16'h0007, "after reset", 1'b0);

    // Invalid digit handling
    run_conv(16'h12A4, "bcd12A4", 1'b0);
    run_conv(16'h0042, "bcd0042", 1'b0);

    // Random valid BCD words
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(9));
      run_conv(v, $sformatf("rand%0d %h", n, v), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
